// File: rtl/cnn_feeder_pkg.sv
// Shared types and sizing helpers for the CNN row feeder.
package cnn_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_IMG = 2'd1,
        LOAD_WT  = 2'd2
    } state_e;

    localparam logic MODE_IMG = 1'b0;
    localparam logic MODE_WT  = 1'b1;

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value n itself (0..n).
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/cnn_row_feeder_if.sv
// Bus bundle between the CNN row feeder and its producer/consumers.
// The interrupt signal exists only when CNN_FEEDER_ABORT_EN is defined.
//
// Handshakes (in_valid/in_ready, row_valid/send, wt_valid/wt_ready): a transfer
// happens on a rising clk edge where both sides are 1; the holder keeps the
// payload stable while its valid is 1 and the other side has not taken it.
interface cnn_row_feeder_if #(
    parameter int WORD_W = 16,
    parameter int ROW_W  = 480
);
    logic              start;
    logic              mode;
    logic              stop;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic [ROW_W-1:0]  row_out;
    logic              row_valid;
    logic              send;
    logic [WORD_W-1:0] wt_data;
    logic              wt_valid;
    logic              wt_ready;
    logic              busy;
    logic              done;
`ifdef CNN_FEEDER_ABORT_EN
    logic              interrupt;
`endif

    modport master (
`ifdef CNN_FEEDER_ABORT_EN
        output interrupt,
`endif
        output start, mode, stop, in_valid, in_data, send, wt_ready,
        input  in_ready, row_out, row_valid, wt_data, wt_valid, busy, done
    );

    modport slave (
`ifdef CNN_FEEDER_ABORT_EN
        input  interrupt,
`endif
        input  start, mode, stop, in_valid, in_data, send, wt_ready,
        output in_ready, row_out, row_valid, wt_data, wt_valid, busy, done
    );

endinterface

// File: rtl/cnn_row_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled image rows.
// The head reads as zero while empty so row_out is clean without a storage reset.
module cnn_row_fifo
    import cnn_feeder_pkg::*;
#(
    parameter int WIDTH = 480,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage write; stale entries are never visible because of the empty mask.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally (power-of-two depth); clear discards all entries.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_row_feeder.sv
// CNN row feeder: packs input words into image rows buffered in a FIFO for the
// row sender, or forwards weight words through a one-entry holding buffer.
// Optional abort input is enabled with the CNN_FEEDER_ABORT_EN macro.
module cnn_row_feeder
    import cnn_feeder_pkg::*;
#(
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = 30,
    parameter int ROWS_PER_IMG  = 32,
    parameter int WT_WORDS      = 64,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    cnn_row_feeder_if.slave              bus,
    output state_e                       dbg_state_o,
    output logic [cnt_w(FIFO_DEPTH)-1:0] dbg_fifo_count_o
);
    localparam int ROW_W = WORD_W * WORDS_PER_ROW;
    localparam int WCW   = idx_w(WORDS_PER_ROW);
    localparam int RCW   = cnt_w(ROWS_PER_IMG);
    localparam int TCW   = cnt_w(WT_WORDS);

    state_e            state_q;
    logic [WCW-1:0]    word_cnt_q;
    logic [RCW-1:0]    push_cnt_q;
    logic [RCW-1:0]    pop_cnt_q;
    logic [TCW-1:0]    wt_acc_q;
    logic [TCW-1:0]    wt_cnt_q;
    logic [ROW_W-1:0]  asm_q;
    logic [ROW_W-1:0]  asm_d;
    logic [WORD_W-1:0] wt_data_q;
    logic              wt_valid_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [ROW_W-1:0]  fifo_head;

    logic              abort;
    logic              last_word;
    logic              rows_all_pushed;
    logic              wt_all_accepted;
    logic              in_ready;
    logic              accept;
    logic              push;
    logic              pop;
    logic              wt_hs;

`ifdef CNN_FEEDER_ABORT_EN
    assign abort = bus.interrupt && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign last_word       = (word_cnt_q == WCW'(WORDS_PER_ROW - 1));
    assign rows_all_pushed = (push_cnt_q == RCW'(ROWS_PER_IMG));
    // Words beyond the block size are refused so none is stranded at done.
    assign wt_all_accepted = (wt_acc_q == TCW'(WT_WORDS));

    // Input readiness depends on the active transfer kind.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LOAD_IMG: in_ready = !bus.stop && !(fifo_full && last_word) && !rows_all_pushed;
            LOAD_WT:  in_ready = !bus.stop && (!wt_valid_q || bus.wt_ready) && !wt_all_accepted;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && in_ready && !abort;
    assign push   = accept && (state_q == LOAD_IMG) && last_word;
    assign pop    = (state_q == LOAD_IMG) && bus.send && !fifo_empty && !bus.stop && !abort;
    assign wt_hs  = (state_q == LOAD_WT) && wt_valid_q && bus.wt_ready && !bus.stop && !abort;

    // Next assembly value: the accepted word drops into its slot, word 0 in the LSBs.
    always_comb begin
        asm_d = asm_q;
        if (accept && (state_q == LOAD_IMG)) begin
            asm_d[int'(word_cnt_q) * WORD_W +: WORD_W] = bus.in_data;
        end
    end

    cnn_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (abort),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (asm_d),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (dbg_fifo_count_o)
    );

    // Control FSM with its counters, weight buffer and registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            wt_acc_q   <= '0;
            wt_cnt_q   <= '0;
            asm_q      <= '0;
            wt_data_q  <= '0;
            wt_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            asm_q  <= asm_d;
            if (abort) begin
                state_q    <= IDLE;
                word_cnt_q <= '0;
                push_cnt_q <= '0;
                pop_cnt_q  <= '0;
                wt_acc_q   <= '0;
                wt_cnt_q   <= '0;
                wt_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q <= (bus.mode == MODE_WT) ? LOAD_WT : LOAD_IMG;
                        end
                    end
                    LOAD_IMG: begin
                        if (accept) word_cnt_q <= last_word ? '0 : word_cnt_q + WCW'(1);
                        if (push)   push_cnt_q <= push_cnt_q + RCW'(1);
                        if (pop) begin
                            if (pop_cnt_q == RCW'(ROWS_PER_IMG - 1)) begin
                                state_q    <= IDLE;
                                done_q     <= 1'b1;
                                pop_cnt_q  <= '0;
                                push_cnt_q <= '0;
                                word_cnt_q <= '0;
                            end else begin
                                pop_cnt_q <= pop_cnt_q + RCW'(1);
                            end
                        end
                    end
                    LOAD_WT: begin
                        if (accept) begin
                            wt_data_q  <= bus.in_data;
                            wt_valid_q <= 1'b1;
                            wt_acc_q   <= wt_acc_q + TCW'(1);
                        end else if (wt_hs) begin
                            wt_valid_q <= 1'b0;
                        end
                        if (wt_hs) begin
                            if (wt_cnt_q == TCW'(WT_WORDS - 1)) begin
                                state_q    <= IDLE;
                                done_q     <= 1'b1;
                                wt_cnt_q   <= '0;
                                wt_acc_q   <= '0;
                                wt_valid_q <= 1'b0;
                            end else begin
                                wt_cnt_q <= wt_cnt_q + TCW'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.row_out   = fifo_head;
    assign bus.row_valid = !fifo_empty;
    assign bus.wt_data   = wt_data_q;
    assign bus.wt_valid  = wt_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cnn_row_feeder.sv
// Self-checking bench for cnn_row_feeder (small geometry, randomized traffic).
module tb_cnn_row_feeder;
    import cnn_feeder_pkg::*;

    localparam int WORD_W = 16;
    localparam int WPR    = 4;
    localparam int RPI    = 3;
    localparam int WTW    = 4;
    localparam int DEPTH  = 2;
    localparam int ROW_W  = WORD_W * WPR;
    localparam int NWORDS = RPI * WPR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    state_e dbg_state;
    logic [cnt_w(DEPTH)-1:0] dbg_cnt;

    int total = 0;
    int bad   = 0;

    logic [ROW_W-1:0]  exp_q[$];
    logic [WORD_W-1:0] wexp_q[$];
    logic [WORD_W-1:0] src [NWORDS];

    cnn_row_feeder_if #(.WORD_W(WORD_W), .ROW_W(ROW_W)) bus();

    cnn_row_feeder #(
        .WORD_W        (WORD_W),
        .WORDS_PER_ROW (WPR),
        .ROWS_PER_IMG  (RPI),
        .WT_WORDS      (WTW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .dbg_state_o      (dbg_state),
        .dbg_fifo_count_o (dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.stop     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.send     = 1'b0;
        bus.wt_ready = 1'b0;
`ifdef CNN_FEEDER_ABORT_EN
        bus.interrupt = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks / reference helpers ----------------
    task automatic start_xfer(input logic m);
        bus.mode  = m;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic fill_src();
        for (int i = 0; i < NWORDS; i++) src[i] = WORD_W'($urandom);
    endtask

    // Row r of the image is words r*WPR .. r*WPR+WPR-1, first word in the LSBs.
    function automatic logic [ROW_W-1:0] row_of(input int r);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int k = 0; k < WPR; k++) row[k*WORD_W +: WORD_W] = src[r*WPR + k];
        return row;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.row_valid !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got busy=%b in_ready=%b row_valid=%b done=%b want all 0",
                         i, bus.busy, bus.in_ready, bus.row_valid, bus.done);
            end
            step();
        end
        total++;
        if (bus.row_out !== '0 || bus.wt_valid !== 1'b0 || bus.wt_data !== '0) begin
            bad++;
            $display("FAIL reset_data got row_out=%h wt_valid=%b wt_data=%h want 0/0/0",
                     bus.row_out, bus.wt_valid, bus.wt_data);
        end
    endtask

    task automatic test_first_row();
        logic [ROW_W-1:0] want;
        want = 64'h0004_0003_0002_0001;
        do_reset();
        start_xfer(MODE_IMG);
        total++;
        if (dbg_state !== LOAD_IMG || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL first_state got state=%0d busy=%b want %0d/1", dbg_state, bus.busy, LOAD_IMG);
        end
        for (int k = 0; k < WPR; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WORD_W'(k + 1);
            #1;
            total++;
            if (bus.in_ready !== 1'b1 || bus.row_valid !== 1'b0) begin
                bad++;
                $display("FAIL first_fill k=%0d got in_ready=%b row_valid=%b want 1/0", k, bus.in_ready, bus.row_valid);
            end
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.row_valid !== 1'b1 || bus.row_out !== want) begin
            bad++;
            $display("FAIL first_row got valid=%b row=%h want 1/%h", bus.row_valid, bus.row_out, want);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        fill_src();
        start_xfer(MODE_IMG);
        bus.in_valid = 1'b1;
        bus.send     = 1'b0;
        for (int i = 0; i < NWORDS - 1; i++) begin
            bus.in_data = src[i];
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready word=%0d got %b want 1", i, bus.in_ready);
            end
            step();
        end
        bus.in_data = src[NWORDS-1];
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0 || bus.row_out !== row_of(0)) begin
                bad++;
                $display("FAIL full_hold cyc=%0d got in_ready=%b row=%h want 0/%h", i, bus.in_ready, bus.row_out, row_of(0));
            end
            step();
        end
        bus.send = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL pop_cycle_ready got %b want 0", bus.in_ready);
        end
        step();
        bus.send = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL resume_ready got %b want 1", bus.in_ready);
        end
        step();
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL all_pushed_ready got %b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        bus.send     = 1'b1;
        for (int r = 1; r < RPI; r++) begin
            total++;
            if (bus.row_valid !== 1'b1 || bus.row_out !== row_of(r)) begin
                bad++;
                $display("FAIL drain_row r=%0d got valid=%b row=%h want 1/%h", r, bus.row_valid, bus.row_out, row_of(r));
            end
            step();
        end
        bus.send = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL img_done got done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.row_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_once got done=%b row_valid=%b want 0/0", bus.done, bus.row_valid);
        end
    endtask

    // Random image transfer scored against rows packed straight from the source words.
    task automatic run_image(input int valid_pct, input int send_pct, input int stop_from, input int stop_len);
        int  wi;
        int  pops;
        bit  fin;
        bit  stp;
        do_reset();
        fill_src();
        exp_q.delete();
        for (int r = 0; r < RPI; r++) exp_q.push_back(row_of(r));
        start_xfer(MODE_IMG);
        wi   = 0;
        pops = 0;
        fin  = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            stp          = (c >= stop_from) && (c < stop_from + stop_len);
            bus.stop     = stp;
            bus.in_valid = (wi < NWORDS) && ($urandom_range(99) < valid_pct);
            bus.in_data  = (wi < NWORDS) ? src[wi] : WORD_W'($urandom);
            bus.send     = ($urandom_range(99) < send_pct);
            #1;
            if (stp) begin
                total++;
                if (bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stop_ready cyc=%0d got %b want 0", c, bus.in_ready);
                end
            end
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL img_busy cyc=%0d got done=%b busy=%b want 0/1", c, bus.done, bus.busy);
            end
            if (bus.in_valid && bus.in_ready) wi++;
            if (bus.send && bus.row_valid && !stp) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL img_extra_pop cyc=%0d got row=%h want none", c, bus.row_out);
                end else if (bus.row_out !== exp_q[0]) begin
                    bad++;
                    $display("FAIL img_row pop=%0d got %h want %h", pops, bus.row_out, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                pops++;
            end
            step();
            if (pops == RPI) fin = 1'b1;
        end
        idle_inputs();
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL img_timeout got pops=%0d want %0d", pops, RPI);
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL img_end got done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
        step();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL img_done_pulse got %b want 0", bus.done);
        end
    endtask

    task automatic test_stop();
        run_image(100, 50, 2, 5);
    endtask

    task automatic test_random_image();
        run_image(70, 60, 1000, 0);
        run_image(40, 90, 6, 3);
    endtask

    task automatic test_weight();
        int               wi;
        int               hs;
        bit               fin;
        bit               m_held;
        logic [WORD_W-1:0] m_data;
        bit               exp_rdy;
        do_reset();
        wexp_q.delete();
        for (int i = 0; i < WTW; i++) wexp_q.push_back(WORD_W'(16'hA000 + i));
        start_xfer(MODE_WT);
        wi = 0; hs = 0; fin = 1'b0; m_held = 1'b0; m_data = '0;
        for (int c = 0; c < 100 && !fin; c++) begin
            bus.wt_ready = c[0];
            bus.in_valid = (wi < WTW);
            bus.in_data  = WORD_W'(16'hA000 + wi);
            #1;
            exp_rdy = !m_held || bus.wt_ready;
            if (wi < WTW) begin
                total++;
                if (bus.in_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL wt_in_ready cyc=%0d got %b want %b", c, bus.in_ready, exp_rdy);
                end
            end
            total++;
            if (bus.wt_valid !== m_held || (m_held && bus.wt_data !== m_data)) begin
                bad++;
                $display("FAIL wt_hold cyc=%0d got valid=%b data=%h want %b/%h", c, bus.wt_valid, bus.wt_data, m_held, m_data);
            end
            if (m_held && bus.wt_ready) begin
                total++;
                if (wexp_q.size() == 0 || bus.wt_data !== wexp_q[0]) begin
                    bad++;
                    $display("FAIL wt_order hs=%0d got %h want %h", hs, bus.wt_data, (wexp_q.size() != 0) ? wexp_q[0] : '0);
                end
                if (wexp_q.size() != 0) void'(wexp_q.pop_front());
                hs++;
                m_held = 1'b0;
            end
            if (bus.in_valid && exp_rdy && wi < WTW) begin
                m_held = 1'b1;
                m_data = bus.in_data;
                wi++;
            end
            step();
            if (hs == WTW) fin = 1'b1;
        end
        idle_inputs();
        total++;
        if (!fin || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wt_done got fin=%0d done=%b busy=%b want 1/1/0", fin, bus.done, bus.busy);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.wt_valid !== 1'b0) begin
            bad++;
            $display("FAIL wt_after got done=%b wt_valid=%b want 0/0", bus.done, bus.wt_valid);
        end
    endtask

    // Buffer one row plus a partial word, then leave the transfer via rst.
    task automatic test_rst_mid();
        do_reset();
        fill_src();
        start_xfer(MODE_IMG);
        bus.in_valid = 1'b1;
        for (int i = 0; i < WPR + 1; i++) begin
            bus.in_data = src[i];
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.row_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got row_valid=%b want 1", bus.row_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (bus.row_valid !== 1'b0 || bus.busy !== 1'b0 || bus.row_out !== '0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got row_valid=%b busy=%b row=%h done=%b want 0/0/0/0",
                     bus.row_valid, bus.busy, bus.row_out, bus.done);
        end
    endtask

`ifdef CNN_FEEDER_ABORT_EN
    task automatic test_abort();
        do_reset();
        fill_src();
        start_xfer(MODE_IMG);
        bus.in_valid = 1'b1;
        for (int i = 0; i < WPR + 1; i++) begin
            bus.in_data = src[i];
            step();
        end
        bus.in_valid  = 1'b0;
        bus.interrupt = 1'b1;
        bus.send      = 1'b1;
        step();
        bus.interrupt = 1'b0;
        bus.send      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.row_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL abort cyc=%0d got row_valid=%b busy=%b done=%b want 0/0/0",
                         i, bus.row_valid, bus.busy, bus.done);
            end
            step();
        end
        // A fresh image after abort must start at word 0 with an empty FIFO.
        fill_src();
        start_xfer(MODE_IMG);
        bus.in_valid = 1'b1;
        for (int i = 0; i < WPR; i++) begin
            bus.in_data = src[i];
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.row_valid !== 1'b1 || bus.row_out !== row_of(0)) begin
            bad++;
            $display("FAIL abort_restart got valid=%b row=%h want 1/%h", bus.row_valid, bus.row_out, row_of(0));
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_first_row();
        test_fifo_full();
        test_stop();
        test_random_image();
        test_weight();
        test_rst_mid();
`ifdef CNN_FEEDER_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
